// File: rtl/wb_pkg.sv
// Shared defaults and helper functions for the writeback stage and register file.
package wb_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;

  // Index width for n entries, never below one bit so single-entry vectors stay legal
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Finds the youngest valid writeback channel targeting one register index.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int RIDX_W = 3,
  parameter int WIDX_W = clog2(NUM_WB)
) (
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*RIDX_W-1:0] wb_rd,
  input  logic [RIDX_W-1:0]        target,
  output logic                     hit,
  output logic [WIDX_W-1:0]        win_idx
);

  logic [NUM_WB-1:0] match_s;

  // Ascending scan so the highest-index (youngest) match is the one left standing
  always_comb begin
    hit     = 1'b0;
    win_idx = {WIDX_W{1'b0}};
    match_s = {NUM_WB{1'b0}};
    for (int k = 0; k < NUM_WB; k++) begin
      match_s[k] = wb_valid[k] && (wb_rd[k*RIDX_W +: RIDX_W] == target);
      hit        = hit | match_s[k];
      win_idx    = match_s[k] ? WIDX_W'(k) : win_idx;
    end
  end

endmodule

// File: rtl/multiport_writeback_regfile.sv
// Multi-channel writeback stage with architectural register file, read bypass,
// busy scoreboard, conflict flag and retired-write counter.
module multiport_writeback_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WB   = 2,
  parameter int NUM_RD   = 4,
  parameter int BYPASS   = 1,
  parameter int R0_ZERO  = 0,
  parameter int CNT_W    = 16,
  parameter int RIDX_W   = clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB-1:0]          wb_is_ld,
  input  logic [NUM_WB*RIDX_W-1:0]   wb_rd,
  input  logic [NUM_WB*DATA_W-1:0]   wb_ld_data,
  input  logic [NUM_WB*DATA_W-1:0]   wb_alu_data,
  input  logic                       iss_valid,
  input  logic [RIDX_W-1:0]          iss_rd,
  input  logic [NUM_RD*RIDX_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic                       wb_conflict,
  output logic [CNT_W-1:0]           wb_count
);

  localparam int WIDX_W = clog2(NUM_WB);

  logic [DATA_W-1:0] wb_data_s  [NUM_WB];
  logic [NUM_REGS-1:0] reg_hit_s;
  logic [WIDX_W-1:0] reg_win_s  [NUM_REGS];
  logic [NUM_REGS-1:0] we_s;
  logic [NUM_REGS-1:0] claim_s;
  logic [NUM_RD-1:0]   rd_hit_s;
  logic [WIDX_W-1:0] rd_win_s   [NUM_RD];
  logic [RIDX_W-1:0] rd_addr_s  [NUM_RD];
  logic                conflict_s;

  logic [DATA_W-1:0] regs_r     [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic                conflict_r;
  logic [CNT_W-1:0]    count_r;

  // Per-channel result select between load and ALU data
  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wb_data_s[k] = wb_is_ld[k] ? wb_ld_data[k*DATA_W +: DATA_W]
                                 : wb_alu_data[k*DATA_W +: DATA_W];
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg_arb
    wb_port_arbiter #(
      .NUM_WB (NUM_WB),
      .RIDX_W (RIDX_W),
      .WIDX_W (WIDX_W)
    ) u_arb (
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .target   (RIDX_W'(r)),
      .hit      (reg_hit_s[r]),
      .win_idx  (reg_win_s[r])
    );
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_arb
    wb_port_arbiter #(
      .NUM_WB (NUM_WB),
      .RIDX_W (RIDX_W),
      .WIDX_W (WIDX_W)
    ) u_arb (
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .target   (rd_addr[p*RIDX_W +: RIDX_W]),
      .hit      (rd_hit_s[p]),
      .win_idx  (rd_win_s[p])
    );
  end

  // Write enables and scoreboard claims, masking r0 when it is hardwired
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      we_s[r]    = reg_hit_s[r] && !((R0_ZERO != 0) && (r == 0));
      claim_s[r] = iss_valid && (iss_rd == RIDX_W'(r)) && !((R0_ZERO != 0) && (r == 0));
    end
  end

  // Combinational read ports with optional same-cycle bypass
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr_s[p] = rd_addr[p*RIDX_W +: RIDX_W];
      if ((R0_ZERO != 0) && (rd_addr_s[p] == {RIDX_W{1'b0}})) begin
        rd_data[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[p]                  = 1'b0;
      end else if ((BYPASS != 0) && rd_hit_s[p]) begin
        rd_data[p*DATA_W +: DATA_W] = wb_data_s[rd_win_s[p]];
        // A pending writeback releases the register unless issue re-claims it now
        rd_busy[p] = (iss_valid && (iss_rd == rd_addr_s[p])) ? busy_r[rd_addr_s[p]] : 1'b0;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = regs_r[rd_addr_s[p]];
        rd_busy[p]                  = busy_r[rd_addr_s[p]];
      end
    end
  end

  // Any pair of valid channels sharing a destination is a conflict
  always_comb begin
    conflict_s = 1'b0;
    for (int j = 1; j < NUM_WB; j++) begin
      for (int k = 0; k < j; k++) begin
        conflict_s = conflict_s | (wb_valid[j] && wb_valid[k] &&
                     (wb_rd[j*RIDX_W +: RIDX_W] == wb_rd[k*RIDX_W +: RIDX_W]));
      end
    end
  end

  // Architectural state, scoreboard, conflict flag and retired-write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
      end
      busy_r     <= {NUM_REGS{1'b0}};
      conflict_r <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (we_s[r]) begin
          regs_r[r] <= wb_data_s[reg_win_s[r]];
        end
      end
      busy_r     <= (busy_r & ~reg_hit_s) | claim_s;
      conflict_r <= conflict_s;
      count_r    <= count_r + CNT_W'(popcount(32'(wb_valid)));
    end
  end

  assign busy_vec    = busy_r;
  assign wb_conflict = conflict_r;
  assign wb_count    = count_r;

endmodule

// File: tb/tb_multiport_writeback_regfile.sv
// Randomized and directed bench: two builds (default, and R0_ZERO=1 with a 4-bit counter)
// share stimulus and are checked against an array-based reference model.
module tb_multiport_writeback_regfile;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int NW  = 2;
  localparam int NRD = 4;
  localparam int RI  = 3;

  logic            clk;
  logic            rst_n;
  logic [NW-1:0]   wb_valid;
  logic [NW-1:0]   wb_is_ld;
  logic [NW*RI-1:0] wb_rd;
  logic [NW*DW-1:0] wb_ld_data;
  logic [NW*DW-1:0] wb_alu_data;
  logic            iss_valid;
  logic [RI-1:0]   iss_rd;
  logic [NRD*RI-1:0] rd_addr;

  logic [NRD*DW-1:0] a_rd_data, b_rd_data;
  logic [NRD-1:0]    a_rd_busy, b_rd_busy;
  logic [NR-1:0]     a_busy_vec, b_busy_vec;
  logic              a_conflict, b_conflict;
  logic [15:0]       a_count;
  logic [3:0]        b_count;

  logic [DW-1:0] m_regs_a [NR];
  logic [DW-1:0] m_regs_b [NR];
  logic [NR-1:0] m_busy_a, m_busy_b;
  logic          m_conf;
  logic [31:0]   m_cnt;

  int n_checks;
  int n_errs;

  multiport_writeback_regfile #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_WB(NW), .NUM_RD(NRD),
    .BYPASS(1), .R0_ZERO(0), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_is_ld(wb_is_ld), .wb_rd(wb_rd),
    .wb_ld_data(wb_ld_data), .wb_alu_data(wb_alu_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .busy_vec(a_busy_vec), .wb_conflict(a_conflict), .wb_count(a_count)
  );

  multiport_writeback_regfile #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_WB(NW), .NUM_RD(NRD),
    .BYPASS(1), .R0_ZERO(1), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_is_ld(wb_is_ld), .wb_rd(wb_rd),
    .wb_ld_data(wb_ld_data), .wb_alu_data(wb_alu_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .busy_vec(b_busy_vec), .wb_conflict(b_conflict), .wb_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RI-1:0] ch_rd(input int k);
    return wb_rd[k*RI +: RI];
  endfunction

  function automatic logic [DW-1:0] ch_data(input int k);
    return wb_is_ld[k] ? wb_ld_data[k*DW +: DW] : wb_alu_data[k*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs_a[r] = '0;
      m_regs_b[r] = '0;
    end
    m_busy_a = '0;
    m_busy_b = '0;
    m_conf   = 1'b0;
    m_cnt    = 32'd0;
  endtask

  // Apply one clock edge of architectural effect in program order
  task automatic model_update();
    m_conf = 1'b0;
    for (int j = 0; j < NW; j++)
      for (int k = j + 1; k < NW; k++)
        if (wb_valid[j] && wb_valid[k] && ch_rd(j) == ch_rd(k)) m_conf = 1'b1;
    for (int k = 0; k < NW; k++) begin
      if (wb_valid[k]) begin
        m_regs_a[ch_rd(k)] = ch_data(k);
        if (ch_rd(k) != 3'd0) m_regs_b[ch_rd(k)] = ch_data(k);
        m_busy_a[ch_rd(k)] = 1'b0;
        m_busy_b[ch_rd(k)] = 1'b0;
        m_cnt = m_cnt + 32'd1;
      end
    end
    if (iss_valid) begin
      m_busy_a[iss_rd] = 1'b1;
      if (iss_rd != 3'd0) m_busy_b[iss_rd] = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [RI-1:0] addr;
    logic [DW-1:0] ea, eb;
    logic          pend, reclaim, ba, bb;
    for (int p = 0; p < NRD; p++) begin
      addr = rd_addr[p*RI +: RI];
      ea = m_regs_a[addr];
      eb = m_regs_b[addr];
      pend = 1'b0;
      for (int k = 0; k < NW; k++) begin
        if (wb_valid[k] && ch_rd(k) == addr) begin
          ea = ch_data(k);
          eb = ch_data(k);
          pend = 1'b1;
        end
      end
      reclaim = iss_valid && (iss_rd == addr);
      ba = (pend && !reclaim) ? 1'b0 : m_busy_a[addr];
      bb = (pend && !reclaim) ? 1'b0 : m_busy_b[addr];
      if (addr == 3'd0) begin
        eb = '0;
        bb = 1'b0;
      end
      check_val($sformatf("a_rd_data[%0d]", p), 32'(a_rd_data[p*DW +: DW]), 32'(ea));
      check_val($sformatf("b_rd_data[%0d]", p), 32'(b_rd_data[p*DW +: DW]), 32'(eb));
      check_val($sformatf("a_rd_busy[%0d]", p), 32'(a_rd_busy[p]), 32'(ba));
      check_val($sformatf("b_rd_busy[%0d]", p), 32'(b_rd_busy[p]), 32'(bb));
    end
    check_val("a_busy_vec", 32'(a_busy_vec), 32'(m_busy_a));
    check_val("b_busy_vec", 32'(b_busy_vec), 32'(m_busy_b));
    check_val("a_conflict", 32'(a_conflict), 32'(m_conf));
    check_val("b_conflict", 32'(b_conflict), 32'(m_conf));
    check_val("a_count", 32'(a_count), 32'(m_cnt[15:0]));
    check_val("b_count", 32'(b_count), 32'(m_cnt[3:0]));
  endtask

  task automatic idle_inputs();
    wb_valid = '0; wb_is_ld = '0; wb_rd = '0;
    wb_ld_data = '0; wb_alu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic rand_inputs();
    wb_valid    = 2'($urandom);
    wb_is_ld    = 2'($urandom);
    wb_rd       = 6'($urandom);
    wb_ld_data  = $urandom;
    wb_alu_data = $urandom;
    iss_valid   = 1'($urandom);
    iss_rd      = 3'($urandom);
    rd_addr     = 12'($urandom);
  endtask

  // From posedge+1: sample at the falling edge, then cross the next rising edge
  task automatic settle();
    #4;
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    idle_inputs();
    rd_addr = '0;
    rst_n = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    // Single ALU write to r3, bypass then stored
    wb_valid = 2'b01; wb_is_ld = 2'b00; wb_rd = {3'd0, 3'd3};
    wb_alu_data = {16'h0000, 16'hBEEF};
    rd_addr = {3'd0, 3'd0, 3'd0, 3'd3};
    settle();
    check_val("bypass_beef", 32'(a_rd_data[15:0]), 32'h0000BEEF);
    advance();
    idle_inputs();
    settle();
    check_val("stored_beef", 32'(a_rd_data[15:0]), 32'h0000BEEF);
    check_val("count_one", 32'(a_count), 32'd1);
    advance();

    // Two channels to r5: younger ALU result wins
    wb_valid = 2'b11; wb_is_ld = 2'b01; wb_rd = {3'd5, 3'd5};
    wb_ld_data = {16'h0000, 16'h1111}; wb_alu_data = {16'h2222, 16'h0000};
    rd_addr = {3'd0, 3'd0, 3'd0, 3'd5};
    settle();
    check_val("bypass_2222", 32'(a_rd_data[15:0]), 32'h00002222);
    advance();
    idle_inputs();
    settle();
    check_val("stored_2222", 32'(a_rd_data[15:0]), 32'h00002222);
    check_val("conflict_set", 32'(a_conflict), 32'd1);
    check_val("count_three", 32'(a_count), 32'd3);
    advance();
    settle();
    check_val("conflict_clr", 32'(a_conflict), 32'd0);
    advance();

    // Scoreboard: claim, claim+writeback, writeback alone
    iss_valid = 1'b1; iss_rd = 3'd2; rd_addr = {3'd0, 3'd0, 3'd2, 3'd0};
    step();
    idle_inputs();
    settle();
    check_val("busy2_set", 32'(a_busy_vec[2]), 32'd1);
    advance();
    wb_valid = 2'b01; wb_rd = {3'd0, 3'd2}; wb_alu_data = 32'h0000_1234;
    iss_valid = 1'b1; iss_rd = 3'd2;
    step();
    idle_inputs();
    settle();
    check_val("busy2_held", 32'(a_busy_vec[2]), 32'd1);
    advance();
    wb_valid = 2'b01; wb_rd = {3'd0, 3'd2}; wb_alu_data = 32'h0000_5678;
    settle();
    check_val("busy2_bypass_free", 32'(a_rd_busy[1]), 32'd0);
    advance();
    idle_inputs();
    settle();
    check_val("busy2_clr", 32'(a_busy_vec[2]), 32'd0);
    advance();

    // r0 write and claim: dropped only in the R0_ZERO build
    wb_valid = 2'b01; wb_rd = {3'd1, 3'd0}; wb_alu_data = 32'h0000_00FF;
    iss_valid = 1'b1; iss_rd = 3'd0; rd_addr = '0;
    settle();
    check_val("b_r0_bypass_zero", 32'(b_rd_data[15:0]), 32'd0);
    advance();
    idle_inputs();
    settle();
    check_val("b_r0_zero", 32'(b_rd_data[15:0]), 32'd0);
    check_val("b_r0_busy", 32'(b_busy_vec[0]), 32'd0);
    check_val("a_r0_ff", 32'(a_rd_data[15:0]), 32'h000000FF);
    check_val("a_r0_busy", 32'(a_busy_vec[0]), 32'd1);
    advance();

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end

    // Async reset mid-cycle, held across an edge carrying writes
    idle_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_val("rst_a_count", 32'(a_count), 32'd0);
    rand_inputs();
    wb_valid = 2'b11;
    @(posedge clk);
    #3;
    idle_inputs();
    rst_n = 1'b1;
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;

    // Counter wrap in the 4-bit build: 14 after seven double cycles, 0 after eight
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      wb_valid = 2'b11;
      if (i == 7) begin
        settle();
        check_val("b_count_14", 32'(b_count), 32'd14);
        advance();
      end else begin
        step();
      end
    end
    idle_inputs();
    settle();
    check_val("b_count_wrap", 32'(b_count), 32'd0);
    check_val("a_count_16", 32'(a_count), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
